// File: rtl/gecko_result_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : gecko_result_arbiter
// Description : Merges PORTS result streams into one registered writeback
//               stream. Fixed-priority (ARB_MODE=0) or round-robin
//               (ARB_MODE=1) arbitration, one transfer per cycle, one cycle
//               latency. Per-port accepted-transfer counters are built only
//               when GECKO_RESULT_ARBITER_STATS_EN is defined; otherwise
//               grant_count reads as constant zero.
// Revision    : 1.0 - initial release
// ============================================================================
module gecko_result_arbiter #(
  parameter int  PORTS    = 3,
  parameter int  ARB_MODE = 0,
  parameter type T        = logic [31:0]
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PORTS-1:0]           results_in_valid,
  output logic [PORTS-1:0]           results_in_ready,
  input  T                           results_in_payload [PORTS],
  output logic                       result_out_valid,
  input  logic                       result_out_ready,
  output T                           result_out_payload,
  output logic [$clog2(PORTS)-1:0]   grant_index,
  output logic [31:0]                grant_count [PORTS]
);

  localparam int          c_IDX_W   = $clog2(PORTS);
  // One extra bit so rotated search positions (ptr + k) never overflow.
  localparam int          c_POS_W   = c_IDX_W + 1;
  localparam logic [31:0] c_CNT_MAX = 32'hFFFF_FFFF;

  logic               r_out_valid;
  T                   r_out_payload;
  logic [c_IDX_W-1:0] r_out_index;
  logic [c_IDX_W-1:0] r_rr_ptr;

  logic               w_load;
  logic               w_grant_valid;
  logic [c_IDX_W-1:0] w_grant_idx;
  logic [c_IDX_W-1:0] w_base;
  logic [c_POS_W-1:0] w_pos;

  // The output register may take a new entry when empty or being drained.
  assign w_load = !r_out_valid || result_out_ready;

  // Fixed priority searches from port 0; round-robin starts at the pointer.
  assign w_base = (ARB_MODE == 1) ? r_rr_ptr : '0;

  // Pick the first valid port in search order starting at w_base, wrapping.
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant_idx   = '0;
    w_pos         = '0;
    for (int k = 0; k < PORTS; k++) begin
      w_pos = {1'b0, w_base} + c_POS_W'(k);
      if (w_pos >= c_POS_W'(PORTS)) begin
        w_pos = w_pos - c_POS_W'(PORTS);
      end
      if (!w_grant_valid && results_in_valid[w_pos[c_IDX_W-1:0]]) begin
        w_grant_valid = 1'b1;
        w_grant_idx   = w_pos[c_IDX_W-1:0];
      end
    end
  end

  // Only the granted port sees ready, and only while the output can load.
  for (genvar gi = 0; gi < PORTS; gi++) begin : g_ready
    assign results_in_ready[gi] = !rst && w_load && w_grant_valid &&
                                  (w_grant_idx == c_IDX_W'(gi));
  end

  // Output entry: capture the granted payload, or empty out when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid   <= 1'b0;
      r_out_payload <= '0;
      r_out_index   <= '0;
    end else if (w_load) begin
      r_out_valid <= w_grant_valid;
      if (w_grant_valid) begin
        r_out_payload <= results_in_payload[w_grant_idx];
        r_out_index   <= w_grant_idx;
      end
    end
  end

  // Round-robin pointer moves just past the winner after every grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_load && w_grant_valid) begin
      if (w_grant_idx == c_IDX_W'(PORTS - 1)) begin
        r_rr_ptr <= '0;
      end else begin
        r_rr_ptr <= w_grant_idx + c_IDX_W'(1);
      end
    end
  end

  assign result_out_valid   = r_out_valid;
  assign result_out_payload = r_out_payload;
  assign grant_index        = r_out_index;

`ifdef GECKO_RESULT_ARBITER_STATS_EN
  for (genvar gi = 0; gi < PORTS; gi++) begin : g_stats
    logic [31:0] r_count;

    // Saturating count of accepted input handshakes on this port.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_count <= '0;
      end else if (results_in_valid[gi] && results_in_ready[gi] &&
                   (r_count != c_CNT_MAX)) begin
        r_count <= r_count + 32'd1;
      end
    end

    assign grant_count[gi] = r_count;
  end
`else
  for (genvar gi = 0; gi < PORTS; gi++) begin : g_no_stats
    assign grant_count[gi] = 32'd0;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_gecko_result_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_gecko_result_arbiter
// Description : Scoreboard bench for gecko_result_arbiter. Three instances
//               (3-port fixed priority, 3-port round-robin, 4-port
//               round-robin) share one stimulus; a reference model predicts
//               each grant and a monitor compares the DUT outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gecko_result_arbiter;

`ifdef GECKO_RESULT_ARBITER_STATS_EN
  localparam bit c_STATS = 1'b1;
`else
  localparam bit c_STATS = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [3:0]  v;
  logic        rdy;
  logic [31:0] pl [4];
  logic [31:0] p3 [3];

  logic [2:0]  a_rdy, b_rdy;
  logic [3:0]  c_rdy;
  logic        a_ov, b_ov, c_ov;
  logic [31:0] a_op, b_op, c_op;
  logic [1:0]  a_idx, b_idx, c_idx;
  logic [31:0] a_cnt [3];
  logic [31:0] b_cnt [3];
  logic [31:0] c_cnt [4];

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 3; i++) p3[i] = pl[i];
  end

  gecko_result_arbiter #(.PORTS(3), .ARB_MODE(0), .T(logic [31:0])) u_a (
    .clk(clk), .rst(rst),
    .results_in_valid(v[2:0]), .results_in_ready(a_rdy), .results_in_payload(p3),
    .result_out_valid(a_ov), .result_out_ready(rdy), .result_out_payload(a_op),
    .grant_index(a_idx), .grant_count(a_cnt));

  gecko_result_arbiter #(.PORTS(3), .ARB_MODE(1), .T(logic [31:0])) u_b (
    .clk(clk), .rst(rst),
    .results_in_valid(v[2:0]), .results_in_ready(b_rdy), .results_in_payload(p3),
    .result_out_valid(b_ov), .result_out_ready(rdy), .result_out_payload(b_op),
    .grant_index(b_idx), .grant_count(b_cnt));

  gecko_result_arbiter #(.PORTS(4), .ARB_MODE(1), .T(logic [31:0])) u_c (
    .clk(clk), .rst(rst),
    .results_in_valid(v), .results_in_ready(c_rdy), .results_in_payload(pl),
    .result_out_valid(c_ov), .result_out_ready(rdy), .result_out_payload(c_op),
    .grant_index(c_idx), .grant_count(c_cnt));

  // ---------------- accessors over the three instances ----------------
  function automatic int np_of(input int k);
    return (k == 2) ? 4 : 3;
  endfunction

  function automatic int md_of(input int k);
    return (k == 0) ? 0 : 1;
  endfunction

  function automatic logic [3:0] rdy_of(input int k);
    case (k)
      0:       return {1'b0, a_rdy};
      1:       return {1'b0, b_rdy};
      default: return c_rdy;
    endcase
  endfunction

  function automatic logic ov_of(input int k);
    case (k)
      0:       return a_ov;
      1:       return b_ov;
      default: return c_ov;
    endcase
  endfunction

  function automatic logic [31:0] op_of(input int k);
    case (k)
      0:       return a_op;
      1:       return b_op;
      default: return c_op;
    endcase
  endfunction

  function automatic logic [7:0] idx_of(input int k);
    case (k)
      0:       return {6'd0, a_idx};
      1:       return {6'd0, b_idx};
      default: return {6'd0, c_idx};
    endcase
  endfunction

  function automatic logic [31:0] cnt_of(input int k, input int i);
    case (k)
      0:       return a_cnt[i];
      1:       return b_cnt[i];
      default: return c_cnt[i];
    endcase
  endfunction

  // Reference arbitration: scan ports in priority order, return -1 if idle.
  function automatic int pick(input logic [3:0] vv, input int n, input int mode, input int ptr);
    for (int k = 0; k < n; k++) begin
      int p;
      p = (mode == 0) ? k : (ptr + k) % n;
      if (vv[p]) return p;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model state ----------------
  bit          m_valid [3];
  int          m_ptr   [3];
  logic [31:0] m_cnt   [3][4];
  logic [39:0] exp_q   [3][$];

  // Predictor: at each edge decide what each DUT accepts and queue it.
  initial begin
    for (int k = 0; k < 3; k++) begin
      m_valid[k] = 1'b0;
      m_ptr[k]   = 0;
      for (int i = 0; i < 4; i++) m_cnt[k][i] = 32'd0;
    end
    forever begin
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
        int g;
        if (rst) begin
          exp_q[k].delete();
          m_valid[k] = 1'b0;
          m_ptr[k]   = 0;
          for (int i = 0; i < 4; i++) m_cnt[k][i] = 32'd0;
        end else if (!m_valid[k] || rdy) begin
          g = pick(v, np_of(k), md_of(k), m_ptr[k]);
          if (g >= 0) begin
            exp_q[k].push_back({8'(g), pl[g]});
            m_valid[k] = 1'b1;
            m_ptr[k]   = (g + 1) % np_of(k);
            if (m_cnt[k][g] != 32'hFFFF_FFFF) m_cnt[k][g] = m_cnt[k][g] + 32'd1;
          end else begin
            m_valid[k] = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: mid-cycle, compare handshakes, held entry and counters.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        logic [3:0]  er;
        logic [39:0] f;
        int          g;
        er = 4'd0;
        if (!rst && (!m_valid[k] || rdy)) begin
          g = pick(v, np_of(k), md_of(k), m_ptr[k]);
          if (g >= 0) er[g] = 1'b1;
        end
        chk($sformatf("dut%0d in_ready", k), 64'(rdy_of(k)), 64'(er));
        chk($sformatf("dut%0d out_valid", k), 64'(ov_of(k)), 64'(m_valid[k]));
        if (m_valid[k] && exp_q[k].size() > 0) begin
          f = exp_q[k][0];
          chk($sformatf("dut%0d grant_index", k), 64'(idx_of(k)), 64'(f[39:32]));
          chk($sformatf("dut%0d payload", k), 64'(op_of(k)), 64'(f[31:0]));
          if (rdy && !rst) void'(exp_q[k].pop_front());
        end
        for (int i = 0; i < np_of(k); i++) begin
          chk($sformatf("dut%0d grant_count[%0d]", k, i), 64'(cnt_of(k, i)),
              c_STATS ? 64'(m_cnt[k][i]) : 64'd0);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_payloads();
    for (int i = 0; i < 4; i++) pl[i] = $urandom;
  endtask

  // Pulse reset for one edge and confirm every instance is cleared.
  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst dut%0d valid", k), 64'(ov_of(k)), 64'd0);
      chk($sformatf("rst dut%0d payload", k), 64'(op_of(k)), 64'd0);
      chk($sformatf("rst dut%0d index", k), 64'(idx_of(k)), 64'd0);
      for (int i = 0; i < np_of(k); i++)
        chk($sformatf("rst dut%0d count%0d", k, i), 64'(cnt_of(k, i)), 64'd0);
    end
  endtask

  logic [31:0] held_a, held_b;
  logic [1:0]  held_ai;

  initial begin
    rst = 1'b1;
    v   = 4'd0;
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) pl[i] = 32'd0;
    step();
    do_reset();

    // All ports valid, output always ready: fixed priority keeps port 0,
    // round-robin rotates through every port.
    v   = 4'hF;
    rdy = 1'b1;
    rand_payloads();
    do_reset();
    for (int j = 0; j < 8; j++) begin
      step();
      chk("fp idx", 64'(a_idx), 64'd0);
      chk("fp ready", 64'(a_rdy), 64'd1);
      chk("rr3 idx", 64'(b_idx), 64'(j % 3));
      chk("rr3 valid", 64'(b_ov), 64'd1);
      chk("rr4 idx", 64'(c_idx), 64'(j % 4));
      rand_payloads();
    end

    // Round-robin wrap on the 4-port instance: 3, then 0, pointer back at 1.
    do_reset();
    v = 4'b1000;
    step();
    chk("wrap first", 64'(c_idx), 64'd3);
    v = 4'b0001;
    step();
    chk("wrap second", 64'(c_idx), 64'd0);
    v = 4'hF;
    step();
    chk("wrap ptr", 64'(c_idx), 64'd1);

    // Back-pressure: output held for 5 cycles, then drain and regrant.
    rdy = 1'b0;
    step();
    held_a  = a_op;
    held_ai = a_idx;
    held_b  = b_op;
    for (int j = 0; j < 5; j++) begin
      rand_payloads();
      step();
      chk("hold a payload", 64'(a_op), 64'(held_a));
      chk("hold a index", 64'(a_idx), 64'(held_ai));
      chk("hold b payload", 64'(b_op), 64'(held_b));
      chk("hold ready", 64'({a_rdy, b_rdy, c_rdy}), 64'd0);
    end
    rdy = 1'b1;
    #1;
    chk("drain grant ready", 64'(a_rdy), 64'd1);
    step();
    chk("drain new payload", 64'(a_op), 64'(pl[0]));

    // Reset while an entry is held: entry lost, next grant from port 0.
    rdy = 1'b0;
    step();
    do_reset();
    rdy = 1'b1;
    step();
    chk("post-rst fp idx", 64'(a_idx), 64'd0);
    chk("post-rst rr3 idx", 64'(b_idx), 64'd0);
    chk("post-rst rr4 idx", 64'(c_idx), 64'd0);

    // Ten handshakes on port 2 only.
    do_reset();
    v = 4'b0100;
    for (int j = 0; j < 10; j++) step();
    v = 4'd0;
    step();
    step();
    chk("stats port2", 64'(a_cnt[2]), c_STATS ? 64'd10 : 64'd0);
    chk("stats port0", 64'(a_cnt[0]), 64'd0);
    chk("stats port1", 64'(a_cnt[1]), 64'd0);

    // Randomised traffic with sporadic back-pressure and reset.
    for (int j = 0; j < 400; j++) begin
      v   = 4'($urandom);
      rdy = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 49) == 0);
      rand_payloads();
      step();
    end
    rst = 1'b0;
    v   = 4'd0;
    rdy = 1'b1;
    for (int j = 0; j < 4; j++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gecko_result_arbiter.md
GECKO_RESULT_ARBITER -- requirements
Module: gecko_result_arbiter

Interface
REQ-001 Parameter: PORTS, default 3, number of result input streams; legal range 2..8.
REQ-002 Parameter: ARB_MODE, default 0, arbitration policy; 0 = fixed priority, 1 = round-robin.
REQ-003 Parameter: T, default gecko_operation_t, payload type carried on all streams.
REQ-004 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port: rst  input  1  synchronous, active-high reset.
REQ-006 Port: results_in[PORTS]  std_stream_intf.in  $bits(T) per port  result producers (execute, memory, system, ...).
REQ-007 Port: result_out  std_stream_intf.out  $bits(T)  merged writeback stream.
REQ-008 Port: grant_index  output  $clog2(PORTS)  index of the port whose payload currently occupies result_out.
REQ-009 Port: grant_count[PORTS]  output  32 each  accepted-transfer count per port (see Configuration).

Function
REQ-010 Block SHALL hold a single registered output entry (out_valid, out_payload, out_index); result_out.valid = out_valid, result_out.payload = out_payload, grant_index = out_index.
REQ-011 Load enable SHALL be load = !out_valid || result_out.ready; a new input is captured only when load is 1.
REQ-012 When load is 1 and at least one results_in[i].valid is 1, exactly one port g SHALL be granted; results_in[g].ready = 1; all other ready = 0.
REQ-013 When load is 0, all results_in[i].ready SHALL be 0.
REQ-014 ready SHALL depend only on load and the valid vector; no valid depends on ready (no combinational loop).
REQ-015 On a grant, next cycle out_valid = 1, out_payload = results_in[g].payload, out_index = g: latency exactly 1 cycle from input handshake to result_out.valid.
REQ-016 When load is 1 and no input is valid, out_valid SHALL become 0 on the next edge.
REQ-017 Simultaneous output drain and new grant SHALL sustain 1 transfer/cycle with no bubble.
REQ-018 ARB_MODE 0: g = lowest index with valid = 1.
REQ-019 ARB_MODE 1: g = first valid index searching rr_ptr, rr_ptr+1, ... modulo PORTS; after each grant rr_ptr = (g + 1) mod PORTS; rr_ptr unchanged when no grant.
REQ-020 Round-robin wrap: with rr_ptr = PORTS-1 and port PORTS-1 idle, search SHALL continue at port 0.
REQ-021 A payload held in the output register SHALL remain stable while result_out.valid = 1 and result_out.ready = 0.
REQ-022 Inputs not granted SHALL be left untouched; no payload is dropped or duplicated.

Reset
REQ-023 On rst = 1: out_valid = 0, out_payload = 0, out_index = 0, rr_ptr = 0, all grant_count = 0, all results_in[i].ready = 0.
REQ-024 Reset asserted mid-transfer SHALL discard the held entry; first grant after reset follows REQ-018/REQ-019 with rr_ptr = 0.

Configuration
REQ-025 Macro GECKO_RESULT_ARBITER_STATS_EN SHALL control transfer statistics.
REQ-026 With macro defined: grant_count[i] increments by 1 on each accepted handshake on port i, saturating at 32'hFFFF_FFFF, cleared by rst.
REQ-027 Without macro: grant_count[i] SHALL be constant 0, no counter registers synthesised; arbitration behaviour identical.

Verification
REQ-028 PORTS=3, ARB_MODE=0, all ports valid continuously, result_out.ready=1 -> port 0 granted every cycle, ports 1,2 ready=0, grant_index=0.
REQ-029 PORTS=3, ARB_MODE=1, all ports valid continuously, ready=1 -> grant_index sequence 0,1,2,0,1,2 on consecutive cycles, one transfer/cycle.
REQ-030 PORTS=4, ARB_MODE=1, only port 3 then only port 0 valid -> grants 3 then 0 (wrap), rr_ptr returns to 1.
REQ-031 Output held with result_out.ready=0 for 5 cycles, all inputs valid -> all input ready=0, payload and grant_index stable, no counter change; ready=1 -> drain and next grant in same cycle.
REQ-032 Transfer in flight, rst pulsed 1 cycle -> result_out.valid=0 next cycle, grant_count all 0, next grant is port 0.
REQ-033 STATS_EN defined, 10 handshakes on port 2 -> grant_count[2]=10, others 0; without macro -> all 0.
